// File: rtl/uart_tx_chunk_serializer_if.sv
// Handshake bundle between the scheduler / UART TX side (master) and the
// chunk serializer (slave).
interface uart_tx_chunk_if #(
  parameter int CONTENT_BUFFER_BYTE_SIZE  = 5,
  parameter int CONTENT_BUFFER_INDEX_SIZE = 32
);
  logic                                   is_chunk_ready;
  logic [7:0]                             chunk_type;
  logic [CONTENT_BUFFER_INDEX_SIZE-1:0]   chunk_byte_size;
  logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0]  chunk_bytes;
  logic                                   is_tx_done;
  logic                                   is_tx_ready;
  logic [7:0]                             tx_data;
  logic                                   is_busy;
  logic                                   is_chunker_done;

  modport master (
    output is_chunk_ready, chunk_type, chunk_byte_size, chunk_bytes, is_tx_done,
    input  is_tx_ready, tx_data, is_busy, is_chunker_done
  );

  modport slave (
    input  is_chunk_ready, chunk_type, chunk_byte_size, chunk_bytes, is_tx_done,
    output is_tx_ready, tx_data, is_busy, is_chunker_done
  );
endinterface

// File: rtl/uart_tx_chunk_serializer.sv
// Chunk serializer: frames one chunk as type, len, content bytes (and an
// optional XOR checksum) and feeds it byte by byte to a UART TX.
// Optional feature macro: UART_TX_CHUNK_CHECKSUM_EN (appends XOR checksum).
module uart_tx_chunk_serializer #(
  parameter int CONTENT_BUFFER_BYTE_SIZE  = 5,
  parameter int CONTENT_BUFFER_INDEX_SIZE = 32
) (
  input  logic             CLK,
  input  logic             reset,
  uart_tx_chunk_if.slave   bus
);
  localparam int BS        = CONTENT_BUFFER_BYTE_SIZE;
  localparam int IW        = CONTENT_BUFFER_INDEX_SIZE;
  localparam int LEN_LIMIT = (BS < 255) ? BS : 255;
  localparam int SEL_W     = (BS > 1) ? $clog2(BS) : 1;
  localparam logic [IW-1:0] LIMIT_W = IW'(LEN_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;          // index of the byte currently on the wire
  logic [7:0] len_q, len_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] content_q [BS];
  logic [7:0] content_d [BS];
`ifdef UART_TX_CHUNK_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] csum_in;
`endif

  logic [7:0] in_bytes [BS];
  logic [7:0] len_clamped;
  logic [8:0] last_idx;
  logic [8:0] nidx;
  logic [8:0] cidx;
  logic [7:0] next_byte;

  // Unpack the flat content bus into byte lanes, byte 0 at the bottom
  generate
    for (genvar gi = 0; gi < BS; gi++) begin : g_unpack
      assign in_bytes[gi] = bus.chunk_bytes[8*gi +: 8];
    end
  endgenerate

  // Clamp the requested size at full input width so large sizes never wrap
  always_comb begin
    len_clamped = bus.chunk_byte_size[7:0];
    if (bus.chunk_byte_size >= LIMIT_W) len_clamped = 8'(LEN_LIMIT);
  end

`ifdef UART_TX_CHUNK_CHECKSUM_EN
  // XOR of type, len and the valid content bytes, computed at acceptance
  always_comb begin
    csum_in = bus.chunk_type ^ len_clamped;
    for (int i = 0; i < BS; i++) begin
      if (i < int'({24'd0, len_clamped})) csum_in = csum_in ^ in_bytes[i];
    end
  end
  assign last_idx = {1'b0, len_q} + 9'd2;
`else
  assign last_idx = {1'b0, len_q} + 9'd1;
`endif

  assign nidx = cnt_q + 9'd1;
  assign cidx = nidx - 9'd2;

  // Select the byte that follows the one currently being sent
  always_comb begin
    next_byte = 8'h00;
    if (nidx == 9'd1) begin
      next_byte = len_q;
    end else if (cidx < {1'b0, len_q}) begin
      next_byte = content_q[cidx[SEL_W-1:0]];
    end else begin
`ifdef UART_TX_CHUNK_CHECKSUM_EN
      next_byte = csum_q;
`endif
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    tx_data_d = tx_data_q;
    content_d = content_q;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    bus.is_tx_ready     = 1'b0;
    bus.is_busy         = 1'b0;
    bus.is_chunker_done = 1'b0;
    bus.tx_data         = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.is_chunk_ready) begin
          len_d     = len_clamped;
          content_d = in_bytes;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
          csum_d    = csum_in;
`endif
          cnt_d     = 9'd0;
          tx_data_d = bus.chunk_type;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.is_tx_ready = 1'b1;
        bus.is_busy     = 1'b1;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        bus.is_busy = 1'b1;
        if (bus.is_tx_done) begin
          if (cnt_q < last_idx) begin
            cnt_d     = nidx;
            tx_data_d = next_byte;
            state_d   = S_ISSUE;
          end else begin
            cnt_d   = 9'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        bus.is_chunker_done = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 9'd0;
      len_q     <= 8'd0;
      tx_data_q <= 8'd0;
      for (int i = 0; i < BS; i++) content_q[i] <= 8'd0;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      tx_data_q <= tx_data_d;
      content_q <= content_d;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end
endmodule

// File: doc/uart_tx_chunk_serializer.md
# uart_tx_chunk_serializer

Serializes one typed chunk (type, byte count, content buffer) into a byte stream for the UART TX byte transmitter. It sits between the MinOS scheduler FSM, which presents a chunk with a one-cycle strobe, and the UART TX instance, which is driven one byte at a time with a ready pulse and answers with a done pulse. It frames every chunk with a header and signals completion so the scheduler can start the next virtual-interface transmission.

## Interface
- `CONTENT_BUFFER_BYTE_SIZE`, 5: capacity of `chunk_bytes` in bytes.
- `CONTENT_BUFFER_INDEX_SIZE`, 32: width of `chunk_byte_size`.
- `CLK` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `is_chunk_ready` input 1: one-cycle request strobe.
- `chunk_type` input 8: chunk type byte.
- `chunk_byte_size` input `CONTENT_BUFFER_INDEX_SIZE`: number of content bytes.
- `chunk_bytes` input `CONTENT_BUFFER_BYTE_SIZE*8`: content. Byte i is `[8i+7:8i]`.
- `is_tx_done` input 1: UART TX byte-complete pulse.
- `is_tx_ready` output 1: one-cycle pulse that launches `tx_data`.
- `tx_data` output 8: byte being sent.
- `is_busy` output 1: high from acceptance until the done pulse.
- `is_chunker_done` output 1: one-cycle pulse when the frame is complete.

## Operation
- Frame order:
  - `type`
  - `len`
  - content bytes 0 .. `len-1`, byte 0 first
  - optional checksum (see Configuration)
- `len` is `min(chunk_byte_size, CONTENT_BUFFER_BYTE_SIZE, 255)`, as an 8-bit value. The comparison is done at full input width, so there is no truncation wrap.
- On an accepted strobe, `chunk_type`, the clamped `len` and all of `chunk_bytes` are latched. Inputs may change afterwards without affecting the frame.
- A strobe is accepted only in IDLE. A strobe while busy is dropped silently, with no queuing.
- A zero-length chunk sends `type` and `len`=0 only, then completes.
- States:
  - IDLE: on `is_chunk_ready`, latch and go to ISSUE.
  - ISSUE: pulse `is_tx_ready` with the current byte and go to WAIT.
  - WAIT: on `is_tx_done`, go to ISSUE if bytes remain, otherwise go to DONE.
  - DONE: pulse `is_chunker_done` and go to IDLE.
- A byte counter, sized to hold 0..257, selects header, content or checksum bytes.
- `is_tx_done` is ignored outside WAIT.
- Reset values: all outputs 0, state IDLE, counter 0, latched registers 0.
- Reset mid-frame aborts the frame and produces no done pulse. A byte already started on the serial line finishes in the UART TX, and its `is_tx_done` is ignored.

## Timing
- Strobe accepted at cycle N. At N+1, `is_tx_ready`=1 with `tx_data`=type, and `is_busy`=1 from N+1.
- `is_tx_done` at cycle M, with bytes remaining: at M+1, `is_tx_ready`=1 with the next byte.
- `is_tx_done` for the last byte at cycle M: at M+1, `is_chunker_done`=1 and `is_busy`=0. IDLE is reached at M+2; a strobe is accepted from M+2.
- `is_tx_ready` is never high for more than one cycle. It is never reasserted before the `is_tx_done` of the previous byte.
- `tx_data` is held stable from its `is_tx_ready` pulse until the next pulse or reset.
- Strobe coinciding with `is_tx_done` while busy: the strobe is dropped and the `is_tx_done` is processed normally.
- `is_tx_done` coinciding with `reset`: reset wins.

## Configuration
- `UART_TX_CHUNK_CHECKSUM_EN` defined:
  - After the last content byte, one extra byte is sent: the XOR of type, `len` and all content bytes.
  - The frame length is `len`+3.
  - The checksum is sent even for `len`=0, in which case it equals type XOR 0.
- Undefined:
  - No checksum byte; the frame length is `len`+2.
  - No checksum logic is present.

## Test plan
- Basic frame: type=0x02, size=1, bytes[7:0]=0xA5, with a UART model returning done 10 cycles after each ready. Required: bytes 0x02, 0x01, 0xA5 each pulsed once, then one done pulse, with `is_busy` high throughout. With the checksum enabled, a fourth byte 0xA6 follows.
- Clamp: size=9 with buffer size 5 and bytes 0x11..0x55. Required: `len`=0x05 followed by exactly 0x11, 0x22, 0x33, 0x44, 0x55. Also size=0x1_0000_0003 (width 40 config) → `len`=5, with no wrap to 3.
- Zero length: type=0x04, size=0. Required: only 0x04, 0x00 (plus checksum 0x04 if enabled), then done.
- Busy drop: a second strobe with type=0x07 mid-frame, and another in the same cycle as the last `is_tx_done`. Required: the first frame is unaltered, no 0x07 is emitted, and exactly one done pulse occurs.
- Reset mid-frame: assert `reset` while in WAIT on the content byte, with `is_tx_done` arriving during reset. Required: all outputs 0, no done pulse, and a following strobe produces a complete correct frame.
- Spurious done: `is_tx_done` pulses while IDLE. Required: no output activity.
